// File: rtl/alu_op_sequencer_if.sv
// Operand/opcode/result bundle between the key-driven sequencer and the shared ALU.
// The master side presents operands and opcode; the slave side returns result and flags.
interface alu_op_sequencer_if #(
   parameter int OP_W = 4
);

   logic [31:0]     port_a;
   logic [31:0]     port_b;
   logic [OP_W-1:0] alu_op;
   logic [31:0]     port_o;
   logic            negative;
   logic            zero;
   logic            overflow;

   modport master (
      output port_a,
      output port_b,
      output alu_op,
      input  port_o,
      input  negative,
      input  zero,
      input  overflow
   );

   modport slave (
      input  port_a,
      input  port_b,
      input  alu_op,
      output port_o,
      output negative,
      output zero,
      output overflow
   );

endinterface

// File: rtl/alu_op_sequencer.sv
// Debounces the ENTER/CLEAR board keys and steps a small FSM that loads A, B and the
// opcode from the switches, fires one ALU evaluation and holds the result for display.
module alu_op_sequencer #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int OP_W            = 4
) (
   input  logic                     CLK,
   input  logic                     nRST,
   input  logic                     enter_n,
   input  logic                     clear_n,
   input  logic [16:0]              sw,
   alu_op_sequencer_if.master       alu,
   output logic [31:0]              disp_value,
   output logic [2:0]               flags_q,
   output logic [2:0]               state_q,
   output logic                     busy
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {
      LOAD_A  = 3'd0,
      LOAD_B  = 3'd1,
      LOAD_OP = 3'd2,
      EXEC    = 3'd3,
      SHOW    = 3'd4
   } state_t;

   // Index 0 is ENTER, index 1 is CLEAR.
   logic [1:0]            key_raw;
   logic [1:0]            sync1_q;
   logic [1:0]            sync2_q;
   logic [1:0]            level_q;
   logic [1:0]            press_q;
   logic [1:0][CNT_W-1:0] cnt_q;

   logic press_enter;
   logic press_clear;

   state_t state;
   state_t state_d;

   logic [31:0]     a_q;
   logic [31:0]     b_q;
   logic [31:0]     res_q;
   logic [OP_W-1:0] op_q;
   logic [31:0]     ext;

   logic load_a;
   logic load_b;
   logic load_op;
   logic capture;
   logic clear_flags;

   assign key_raw     = {clear_n, enter_n};
   assign press_enter = press_q[0];
   assign press_clear = press_q[1];
   assign ext         = {{16{sw[16]}}, sw[15:0]};

   // The counter only advances while the synchronized sample disagrees with the accepted
   // level, so any bounce back to the old level restarts the qualification window.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
         level_q <= 2'b11;
         press_q <= 2'b00;
         cnt_q   <= '0;
      end else begin
         sync1_q <= key_raw;
         sync2_q <= sync1_q;
         press_q <= 2'b00;
         for (int k = 0; k < 2; k++) begin
            if (sync2_q[k] == level_q[k]) begin
               cnt_q[k] <= '0;
            end else if (cnt_q[k] == CNT_MAX) begin
               cnt_q[k]   <= '0;
               level_q[k] <= sync2_q[k];
               press_q[k] <= ~sync2_q[k];
            end else begin
               cnt_q[k] <= cnt_q[k] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= LOAD_A;
      end else begin
         state <= state_d;
      end
   end

   // CLEAR outranks ENTER everywhere except EXEC, which always finishes its capture.
   always_comb begin
      state_d     = state;
      load_a      = 1'b0;
      load_b      = 1'b0;
      load_op     = 1'b0;
      capture     = 1'b0;
      clear_flags = 1'b0;
      if (press_clear && (state != EXEC)) begin
         state_d     = LOAD_A;
         clear_flags = 1'b1;
      end else begin
         case (state)
            LOAD_A: begin
               if (press_enter) begin
                  load_a  = 1'b1;
                  state_d = LOAD_B;
               end
            end
            LOAD_B: begin
               if (press_enter) begin
                  load_b  = 1'b1;
                  state_d = LOAD_OP;
               end
            end
            LOAD_OP: begin
               if (press_enter) begin
                  load_op = 1'b1;
                  state_d = EXEC;
               end
            end
            EXEC: begin
               capture = 1'b1;
               state_d = SHOW;
            end
            SHOW: begin
               if (press_enter) begin
                  state_d = LOAD_A;
               end
            end
            default: begin
               state_d = LOAD_A;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         a_q     <= 32'h0;
         b_q     <= 32'h0;
         op_q    <= '0;
         res_q   <= 32'h0;
         flags_q <= 3'b000;
      end else begin
         if (load_a) begin
            a_q <= ext;
         end
         if (load_b) begin
            b_q <= ext;
         end
         if (load_op) begin
            op_q <= sw[OP_W-1:0];
         end
         if (capture) begin
            res_q   <= alu.port_o;
            flags_q <= {alu.overflow, alu.zero, alu.negative};
         end else if (clear_flags) begin
            flags_q <= 3'b000;
         end
      end
   end

   // While loading, the display echoes what the switches would capture.
   always_comb begin
      disp_value = res_q;
      case (state)
         LOAD_A, LOAD_B: disp_value = ext;
         LOAD_OP:        disp_value = {28'h0, sw[3:0]};
         default:        disp_value = res_q;
      endcase
   end

   assign alu.port_a = a_q;
   assign alu.port_b = b_q;
   assign alu.alu_op = op_q;
   assign state_q    = state;
   assign busy       = (state == EXEC);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench: each key action queues the expected snapshot of the next FSM state
// change, and a monitor compares the DUT outputs whenever state_q moves.
module tb_alu_op_sequencer;

   localparam logic [3:0] ALU_ADD = 4'h1;

   typedef struct packed {
      logic [2:0]  st;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [31:0] disp;
      logic [2:0]  fl;
      logic        bsy;
   } snap_t;

   logic        clk = 1'b0;
   logic        n_rst = 1'b1;
   logic        enter_n = 1'b1;
   logic        clear_n = 1'b1;
   logic [16:0] sw = 17'h1FFFF;
   logic [31:0] disp_value;
   logic [2:0]  flags_q;
   logic [2:0]  state_q;
   logic        busy;
   logic [31:0] sum;

   int    n_checks = 0;
   int    n_fail   = 0;
   bit    start_mon = 1'b0;
   snap_t exp_q[$];

   alu_op_sequencer_if #(.OP_W(4)) bus ();

   alu_op_sequencer #(
      .DEBOUNCE_CYCLES(4),
      .OP_W(4)
   ) dut (
      .CLK(clk),
      .nRST(n_rst),
      .enter_n(enter_n),
      .clear_n(clear_n),
      .sw(sw),
      .alu(bus),
      .disp_value(disp_value),
      .flags_q(flags_q),
      .state_q(state_q),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference ALU: only ADD is modelled, everything else returns zero.
   assign sum          = bus.port_a + bus.port_b;
   assign bus.port_o   = (bus.alu_op == ALU_ADD) ? sum : 32'h0;
   assign bus.zero     = (bus.port_o == 32'h0);
   assign bus.negative = bus.port_o[31];
   assign bus.overflow = (bus.alu_op == ALU_ADD) &&
                         (bus.port_a[31] == bus.port_b[31]) && (sum[31] != bus.port_a[31]);

   function automatic void expect_snap(input logic [2:0] st, input logic [31:0] a,
                                       input logic [31:0] b, input logic [3:0] op,
                                       input logic [31:0] disp, input logic [2:0] fl,
                                       input logic bsy);
      exp_q.push_back('{st: st, a: a, b: b, op: op, disp: disp, fl: fl, bsy: bsy});
   endfunction

   task automatic check_val(input string name, input logic [31:0] actual, input logic [31:0] want);
      n_checks++;
      if (actual !== want) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, want);
      end
   endtask

   task automatic applyStimulus(input logic [16:0] sw_val, input bit use_enter, input bit use_clear);
      sw = sw_val;
      if (use_enter) enter_n = 1'b0;
      if (use_clear) clear_n = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      enter_n = 1'b1;
      clear_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
   endtask

   // Monitor: every state change pops one expected snapshot; EXEC must last one sample.
   initial begin : monitor
      logic [2:0] prev;
      int         dwell;
      snap_t      got;
      snap_t      want;
      wait (start_mon);
      @(negedge clk);
      prev  = state_q;
      dwell = 1;
      forever begin
         @(negedge clk);
         if (state_q !== prev) begin
            if (prev == 3'd3) check_val("exec_dwell", 32'(dwell), 32'd1);
            got = '{st: state_q, a: bus.port_a, b: bus.port_b, op: bus.alu_op,
                    disp: disp_value, fl: flags_q, bsy: busy};
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("[TB] FAIL unexpected_transition: got state %0d, expected no change", state_q);
            end else begin
               want = exp_q.pop_front();
               if (got !== want) begin
                  n_fail++;
                  $display("[TB] FAIL transition: got st=%0d a=%h b=%h op=%h disp=%h fl=%b busy=%b, expected st=%0d a=%h b=%h op=%h disp=%h fl=%b busy=%b",
                           got.st, got.a, got.b, got.op, got.disp, got.fl, got.bsy,
                           want.st, want.a, want.b, want.op, want.disp, want.fl, want.bsy);
               end
            end
            prev  = state_q;
            dwell = 1;
         end else begin
            dwell++;
         end
      end
   end

   initial begin : watchdog
      #200000;
      n_fail++;
      $display("[TB] FAIL watchdog: got timeout, expected end of test");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : stim
      int waited;
      #1 n_rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_state", 32'(state_q), 32'd0);
      check_val("rst_port_a", bus.port_a, 32'h0);
      check_val("rst_port_b", bus.port_b, 32'h0);
      check_val("rst_disp", disp_value, 32'hFFFFFFFF);
      check_val("rst_flags", 32'(flags_q), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      n_rst = 1'b1;
      start_mon = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // 5 + 3 with ADD
      expect_snap(3'd1, 32'h5, 32'h0, 4'h0, 32'h5, 3'b000, 1'b0);
      applyStimulus(17'h00005, 1, 0);
      expect_snap(3'd2, 32'h5, 32'h3, 4'h0, 32'h3, 3'b000, 1'b0);
      applyStimulus(17'h00003, 1, 0);
      expect_snap(3'd3, 32'h5, 32'h3, ALU_ADD, 32'h0, 3'b000, 1'b1);
      expect_snap(3'd4, 32'h5, 32'h3, ALU_ADD, 32'h8, 3'b000, 1'b0);
      applyStimulus(17'h00001, 1, 0);

      // -1 + 1 with ADD gives zero
      expect_snap(3'd0, 32'h5, 32'h3, ALU_ADD, 32'hFFFFFFFF, 3'b000, 1'b0);
      applyStimulus(17'h1FFFF, 1, 0);
      expect_snap(3'd1, 32'hFFFFFFFF, 32'h3, ALU_ADD, 32'hFFFFFFFF, 3'b000, 1'b0);
      applyStimulus(17'h1FFFF, 1, 0);
      expect_snap(3'd2, 32'hFFFFFFFF, 32'h1, ALU_ADD, 32'h1, 3'b000, 1'b0);
      applyStimulus(17'h00001, 1, 0);
      expect_snap(3'd3, 32'hFFFFFFFF, 32'h1, ALU_ADD, 32'h8, 3'b000, 1'b1);
      expect_snap(3'd4, 32'hFFFFFFFF, 32'h1, ALU_ADD, 32'h0, 3'b010, 1'b0);
      applyStimulus(17'h00001, 1, 0);

      // Bouncing ENTER in SHOW: exactly one press back to LOAD_A
      expect_snap(3'd0, 32'hFFFFFFFF, 32'h1, ALU_ADD, 32'h7, 3'b010, 1'b0);
      sw = 17'h00007;
      for (int i = 0; i < 10; i++) begin
         enter_n = (i % 2 == 0) ? 1'b0 : 1'b1;
         repeat (2) @(posedge clk);
         #1;
      end
      enter_n = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      enter_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check_val("bounce_state", 32'(state_q), 32'd0);

      // ENTER and CLEAR together in LOAD_B: clear wins, B untouched
      expect_snap(3'd1, 32'h9, 32'h1, ALU_ADD, 32'h9, 3'b010, 1'b0);
      applyStimulus(17'h00009, 1, 0);
      expect_snap(3'd0, 32'h9, 32'h1, ALU_ADD, 32'h2, 3'b000, 1'b0);
      applyStimulus(17'h00002, 1, 1);

      // 2 + -4 gives a negative result, then CLEAR from SHOW
      expect_snap(3'd1, 32'h2, 32'h1, ALU_ADD, 32'h2, 3'b000, 1'b0);
      applyStimulus(17'h00002, 1, 0);
      expect_snap(3'd2, 32'h2, 32'hFFFFFFFC, ALU_ADD, 32'hC, 3'b000, 1'b0);
      applyStimulus(17'h1FFFC, 1, 0);
      expect_snap(3'd3, 32'h2, 32'hFFFFFFFC, ALU_ADD, 32'h0, 3'b000, 1'b1);
      expect_snap(3'd4, 32'h2, 32'hFFFFFFFC, ALU_ADD, 32'hFFFFFFFE, 3'b001, 1'b0);
      applyStimulus(17'h00001, 1, 0);
      expect_snap(3'd0, 32'h2, 32'hFFFFFFFC, ALU_ADD, 32'h0, 3'b000, 1'b0);
      applyStimulus(17'h00000, 0, 1);

      // Reset during EXEC with ENTER held low across release
      expect_snap(3'd1, 32'h3, 32'hFFFFFFFC, ALU_ADD, 32'h3, 3'b000, 1'b0);
      applyStimulus(17'h00003, 1, 0);
      expect_snap(3'd2, 32'h3, 32'h4, ALU_ADD, 32'h4, 3'b000, 1'b0);
      applyStimulus(17'h00004, 1, 0);
      expect_snap(3'd0, 32'h0, 32'h0, 4'h0, 32'h1, 3'b000, 1'b0);
      expect_snap(3'd1, 32'h1, 32'h0, 4'h0, 32'h1, 3'b000, 1'b0);
      sw = 17'h00001;
      enter_n = 1'b0;
      waited = 0;
      while (waited < 40) begin
         @(posedge clk);
         #1;
         if (busy === 1'b1) break;
         waited++;
      end
      check_val("exec_reached", 32'(waited < 40), 32'd1);
      n_rst = 1'b0;
      #1;
      check_val("exec_rst_state", 32'(state_q), 32'd0);
      check_val("exec_rst_port_a", bus.port_a, 32'h0);
      check_val("exec_rst_port_b", bus.port_b, 32'h0);
      check_val("exec_rst_op", 32'(bus.alu_op), 32'd0);
      check_val("exec_rst_flags", 32'(flags_q), 32'd0);
      check_val("exec_rst_busy", 32'(busy), 32'd0);
      check_val("exec_rst_disp", disp_value, 32'h1);
      repeat (3) @(posedge clk);
      #1;
      n_rst = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check_val("held_key_no_early_press", 32'(state_q), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      check_val("held_key_press", 32'(state_q), 32'd1);
      enter_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;

      checkOutput();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   task automatic checkOutput();
      check_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);
   endtask

endmodule
